// File: rtl/gate_pkg.sv
// Shared op encodings for the multi-input gate pipeline.
// Codes above OP_XNOR are reserved and yield an all-zero result.
package gate_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5
    } gate_op_e;

    function automatic logic op_reserved(input logic [OP_W-1:0] op);
        return (op > OP_XNOR);
    endfunction

endpackage

// File: rtl/gate_reduce.sv
// Combinational bitwise reduction of NrOfInputs operands under a selectable gate.
// Reserved op codes produce zero.
module gate_reduce
    import gate_pkg::*;
#(
    parameter int NrOfBits   = 1,
    parameter int NrOfInputs = 2
) (
    input  logic [NrOfInputs*NrOfBits-1:0] operands,
    input  logic [OP_W-1:0]                op,
    output logic [NrOfBits-1:0]            result
);

    logic [NrOfBits-1:0] and_chain [NrOfInputs];
    logic [NrOfBits-1:0] or_chain  [NrOfInputs];
    logic [NrOfBits-1:0] xor_chain [NrOfInputs];

    assign and_chain[0] = operands[0 +: NrOfBits];
    assign or_chain[0]  = operands[0 +: NrOfBits];
    assign xor_chain[0] = operands[0 +: NrOfBits];

    // Running reductions; the last element of each chain is the full result.
    genvar gi;
    generate
        for (gi = 1; gi < NrOfInputs; gi++) begin : g_chain
            assign and_chain[gi] = and_chain[gi-1] & operands[gi*NrOfBits +: NrOfBits];
            assign or_chain[gi]  = or_chain[gi-1]  | operands[gi*NrOfBits +: NrOfBits];
            assign xor_chain[gi] = xor_chain[gi-1] ^ operands[gi*NrOfBits +: NrOfBits];
        end
    endgenerate

    always_comb begin
        result = '0;
        case (op)
            OP_AND:  result =  and_chain[NrOfInputs-1];
            OP_OR:   result =  or_chain[NrOfInputs-1];
            OP_XOR:  result =  xor_chain[NrOfInputs-1];
            OP_NAND: result = ~and_chain[NrOfInputs-1];
            OP_NOR:  result = ~or_chain[NrOfInputs-1];
            OP_XNOR: result = ~xor_chain[NrOfInputs-1];
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/multi_gate_pipe.sv
// Two-stage valid/ready pipeline: S1 registers bubble-inverted operands, S2 registers the gate result.
// Define GATE_PIPE_STATS_EN to add the 16-bit Beat_Count output-transfer counter.
module multi_gate_pipe
    import gate_pkg::*;
#(
    parameter int                    NrOfBits    = 1,
    parameter int                    NrOfInputs  = 2,
    parameter logic [NrOfInputs-1:0] BubblesMask = '0
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NrOfInputs*NrOfBits-1:0] In_Data,
    input  logic [OP_W-1:0]                In_Op,
    input  logic                           In_Valid,
    output logic                           In_Ready,
    output logic [NrOfBits-1:0]            Out_Data,
    output logic                           Out_Valid,
    input  logic                           Out_Ready,
    output logic                           Op_Error
`ifdef GATE_PIPE_STATS_EN
    ,
    output logic [15:0]                    Beat_Count
`endif
);

    logic                           s1_valid_reg;
    logic [NrOfInputs*NrOfBits-1:0] s1_data_reg;
    logic [OP_W-1:0]                s1_op_reg;
    logic                           out_valid_reg;
    logic [NrOfBits-1:0]            out_data_reg;
    logic                           op_error_reg;

    logic                           s2_free;
    logic                           accept;
    logic [NrOfInputs*NrOfBits-1:0] bubbled_next;
    logic [NrOfBits-1:0]            reduce_result;

    assign s2_free  = !out_valid_reg || Out_Ready;
    assign In_Ready = !reset && (!s1_valid_reg || s2_free);
    assign accept   = In_Valid && In_Ready;

    genvar gi;
    generate
        for (gi = 0; gi < NrOfInputs; gi++) begin : g_bubble
            assign bubbled_next[gi*NrOfBits +: NrOfBits] =
                In_Data[gi*NrOfBits +: NrOfBits] ^ {NrOfBits{BubblesMask[gi]}};
        end
    endgenerate

    gate_reduce #(
        .NrOfBits   (NrOfBits),
        .NrOfInputs (NrOfInputs)
    ) u_reduce (
        .operands (s1_data_reg),
        .op       (s1_op_reg),
        .result   (reduce_result)
    );

    // S1 can only accept while stalled if it is empty, so loading never overwrites a held beat.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1_valid_reg  <= 1'b0;
            s1_data_reg   <= '0;
            s1_op_reg     <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            op_error_reg  <= 1'b0;
        end else begin
            if (s2_free) begin
                out_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    out_data_reg <= reduce_result;
                end
            end
            if (accept) begin
                s1_valid_reg <= 1'b1;
                s1_data_reg  <= bubbled_next;
                s1_op_reg    <= In_Op;
                if (op_reserved(In_Op)) begin
                    op_error_reg <= 1'b1;
                end
            end else if (s2_free) begin
                s1_valid_reg <= 1'b0;
            end
        end
    end

    assign Out_Valid = out_valid_reg;
    assign Out_Data  = out_data_reg;
    assign Op_Error  = op_error_reg;

`ifdef GATE_PIPE_STATS_EN
    logic [15:0] beat_count_reg;

    always_ff @(posedge clock) begin
        if (reset) begin
            beat_count_reg <= '0;
        end else if (out_valid_reg && Out_Ready) begin
            beat_count_reg <= beat_count_reg + 16'd1;
        end
    end

    assign Beat_Count = beat_count_reg;
`endif

endmodule

// File: tb/tb_multi_gate_pipe.sv
// Randomized self-checking bench: a wide 3-input instance with a cycle-level scoreboard,
// plus a narrow bubbled 2-input instance exercised beat by beat.
module tb_multi_gate_pipe;

    localparam int         AW    = 8;
    localparam int         AN    = 3;
    localparam logic [2:0] AMASK = 3'b000;
    localparam int         BW    = 4;
    localparam int         BN    = 2;
    localparam logic [1:0] BMASK = 2'b01;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic [AN*AW-1:0] a_in_data;
    logic [2:0]       a_in_op;
    logic             a_in_valid, a_in_ready;
    logic [AW-1:0]    a_out_data;
    logic             a_out_valid, a_out_ready, a_op_error;
    logic [BN*BW-1:0] b_in_data;
    logic [2:0]       b_in_op;
    logic             b_in_valid, b_in_ready;
    logic [BW-1:0]    b_out_data;
    logic             b_out_valid, b_out_ready, b_op_error;
`ifdef GATE_PIPE_STATS_EN
    logic [15:0]      a_beat_count, b_beat_count;
`endif

    multi_gate_pipe #(.NrOfBits(AW), .NrOfInputs(AN), .BubblesMask(AMASK)) dut_a (
        .clock(clock), .reset(reset),
        .In_Data(a_in_data), .In_Op(a_in_op), .In_Valid(a_in_valid), .In_Ready(a_in_ready),
        .Out_Data(a_out_data), .Out_Valid(a_out_valid), .Out_Ready(a_out_ready),
        .Op_Error(a_op_error)
`ifdef GATE_PIPE_STATS_EN
        , .Beat_Count(a_beat_count)
`endif
    );

    multi_gate_pipe #(.NrOfBits(BW), .NrOfInputs(BN), .BubblesMask(BMASK)) dut_b (
        .clock(clock), .reset(reset),
        .In_Data(b_in_data), .In_Op(b_in_op), .In_Valid(b_in_valid), .In_Ready(b_in_ready),
        .Out_Data(b_out_data), .Out_Valid(b_out_valid), .Out_Ready(b_out_ready),
        .Op_Error(b_op_error)
`ifdef GATE_PIPE_STATS_EN
        , .Beat_Count(b_beat_count)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Per result bit: count the (bubbled) operands that are 1, then apply the gate's truth rule.
    function automatic logic [63:0] ref_gate(input logic [511:0] flat, input int n, input int w,
                                             input logic [7:0] mask, input logic [2:0] op);
        logic [63:0] r;
        int          ones;
        logic        bit_v;
        r = '0;
        for (int b = 0; b < w; b++) begin
            ones = 0;
            for (int i = 0; i < n; i++)
                if ((flat[i*w+b] ^ mask[i]) == 1'b1) ones++;
            case (op)
                3'd0:    bit_v = (ones == n);
                3'd1:    bit_v = (ones != 0);
                3'd2:    bit_v = (ones % 2 == 1);
                3'd3:    bit_v = (ones != n);
                3'd4:    bit_v = (ones == 0);
                3'd5:    bit_v = (ones % 2 == 0);
                default: bit_v = 1'b0;
            endcase
            r[b] = bit_v;
        end
        return r;
    endfunction

    typedef struct {
        logic [AW-1:0] data;
        int            cyc;
    } item_t;

    item_t         q[$];
    int            cyc = 0;
    logic          exp_err = 1'b0;
    logic [15:0]   exp_cnt = '0;
    logic          exp_valid;
    logic          hold_pending = 1'b0;
    logic [AW-1:0] hold_data = '0;

    // Scoreboard for instance A, sampled on the falling edge.
    always @(negedge clock) begin
        exp_valid = 1'b0;
        if (q.size() > 0) exp_valid = ((cyc - q[0].cyc) >= 2);
        check_val("a_in_ready", 64'(a_in_ready), 64'(!reset && (q.size() < 2 || a_out_ready)));
        check_val("a_out_valid", 64'(a_out_valid), 64'(exp_valid));
        check_val("a_op_error", 64'(a_op_error), 64'(exp_err));
`ifdef GATE_PIPE_STATS_EN
        check_val("a_beat_count", 64'(a_beat_count), 64'(exp_cnt));
`endif
        if (hold_pending) check_val("a_hold", 64'(a_out_data), 64'(hold_data));
        hold_pending = !reset && a_out_valid && !a_out_ready;
        hold_data    = a_out_data;
        if (reset) begin
            q.delete();
            exp_err = 1'b0;
            exp_cnt = '0;
        end else begin
            if (a_out_valid && a_out_ready && q.size() > 0) begin
                check_val("a_out_data", 64'(a_out_data), 64'(q[0].data));
                void'(q.pop_front());
                exp_cnt = exp_cnt + 16'd1;
            end
            if (a_in_valid && a_in_ready) begin
                q.push_back('{AW'(ref_gate(512'(a_in_data), AN, AW, 8'(AMASK), a_in_op)), cyc});
                if (a_in_op > 3'd5) exp_err = 1'b1;
            end
        end
        cyc++;
    end

    task automatic a_step(output logic accepted);
        @(negedge clock);
        accepted = a_in_valid && a_in_ready && !reset;
        @(posedge clock);
        #1;
    endtask

    task automatic a_rand_beat();
        a_in_data = AN*AW'($urandom);
        a_in_op   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
    endtask

    logic          acc;
    int            n_acc;
    logic          b_err = 1'b0;
    int            b_beats = 0;
    logic [BW-1:0] b_exp;

    initial begin
        a_in_data = '0; a_in_op = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_op = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check_val("a_rst_data", 64'(a_out_data), 64'd0);
        check_val("b_rst_valid", 64'(b_out_valid), 64'd0);
        check_val("b_rst_ready", 64'(b_in_ready), 64'd0);
        reset = 1'b0;

        // Basic AND: 0xF0 & 0xCC & 0xAA, visible two cycles after acceptance.
        a_in_data = {8'hAA, 8'hCC, 8'hF0}; a_in_op = 3'd0; a_in_valid = 1'b1;
        a_step(acc);
        a_in_valid = 1'b0;
        a_step(acc);
        check_val("a_and_valid", 64'(a_out_valid), 64'd1);
        check_val("a_and_data", 64'(a_out_data), 64'h80);
        repeat (2) a_step(acc);

        // Streaming: 8 back-to-back beats with Out_Ready high.
        for (int i = 0; i < 8; i++) begin
            a_in_data = AN*AW'($urandom); a_in_op = 3'($urandom_range(0, 5)); a_in_valid = 1'b1;
            a_step(acc);
            check_val("a_stream_acc", 64'(acc), 64'd1);
        end
        a_in_valid = 1'b0;
        repeat (3) a_step(acc);

        // Backpressure: 5 stalled cycles admit exactly two beats.
        a_out_ready = 1'b0; a_in_valid = 1'b1; a_rand_beat(); n_acc = 0;
        for (int i = 0; i < 5; i++) begin
            a_step(acc);
            if (acc) begin n_acc++; a_rand_beat(); end
        end
        check_val("a_bp_accepts", 64'(n_acc), 64'd2);
        a_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a_step(acc);
            if (acc) a_rand_beat();
        end
        a_in_valid = 1'b0;
        repeat (3) a_step(acc);

        // Reserved op 7, then a legal op: error stays set.
        a_in_data = AN*AW'($urandom); a_in_op = 3'd7; a_in_valid = 1'b1;
        a_step(acc);
        a_in_op = 3'd1;
        a_step(acc);
        a_in_valid = 1'b0;
        check_val("a_rsv_data", 64'(a_out_data), 64'd0);
        check_val("a_rsv_err", 64'(a_op_error), 64'd1);
        repeat (3) a_step(acc);
        check_val("a_rsv_sticky", 64'(a_op_error), 64'd1);

        // Random valid/ready traffic.
        a_in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!a_in_valid || acc) begin
                a_in_valid = ($urandom_range(0, 3) != 0);
                a_rand_beat();
            end
            a_out_ready = ($urandom_range(0, 3) != 0);
            a_step(acc);
        end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (4) a_step(acc);
        check_val("a_drain", 64'(q.size()), 64'd0);

        // Reset with both stages full and Op_Error set.
        a_in_data = AN*AW'($urandom); a_in_op = 3'd6; a_in_valid = 1'b1; a_out_ready = 1'b0;
        repeat (3) a_step(acc);
        a_in_valid = 1'b0;
        reset = 1'b1;
        a_step(acc);
        check_val("a_mid_rst_valid", 64'(a_out_valid), 64'd0);
        check_val("a_mid_rst_err", 64'(a_op_error), 64'd0);
`ifdef GATE_PIPE_STATS_EN
        check_val("a_mid_rst_cnt", 64'(a_beat_count), 64'd0);
`endif
        reset = 1'b0; a_out_ready = 1'b1;
        a_step(acc);

        // Instance B: bubbled NOR directed case, then random single beats.
        for (int k = 0; k < 20; k++) begin
            if (k == 0) begin
                b_in_data = 8'h53; b_in_op = 3'd4;
            end else begin
                b_in_data = BN*BW'($urandom); b_in_op = 3'($urandom_range(0, 7));
            end
            b_exp = BW'(ref_gate(512'(b_in_data), BN, BW, 8'(BMASK), b_in_op));
            if (b_in_op > 3'd5) b_err = 1'b1;
            b_in_valid = 1'b1;
            check_val("b_in_ready", 64'(b_in_ready), 64'd1);
            @(posedge clock); #1;
            b_in_valid = 1'b0;
            b_beats++;
            @(posedge clock); #1;
            check_val("b_out_valid", 64'(b_out_valid), 64'd1);
            check_val("b_out_data", 64'(b_out_data), 64'(b_exp));
            if (k == 0) check_val("b_nor_bubble", 64'(b_out_data), 64'h2);
            check_val("b_op_error", 64'(b_op_error), 64'(b_err));
            @(posedge clock); #1;
            check_val("b_idle", 64'(b_out_valid), 64'd0);
        end
`ifdef GATE_PIPE_STATS_EN
        check_val("b_beat_count", 64'(b_beat_count), 64'(b_beats));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
